// File: rtl/mem_lsu.sv
// MEM-stage load/store unit in front of a word-wide data memory.
// Ports: req_* request in, stall, dm_* memory side, wb_* load result,
//   exc_* misalign trap (build with LSU_MISALIGN_TRAP_EN to enable).
module mem_lsu #(
  parameter int DM_AW = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [4:0]       req_rd,
  output logic             stall,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  output logic             dm_we,
  output logic             dm_re,
  input  logic [31:0]      dm_rdata,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             exc_misalign,
  output logic [31:0]      exc_addr
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic {IDLE, RMW_WRITE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      merge_reg;
  logic [DM_AW-1:0] addr_reg;

  logic [DM_AW-1:0] req_word;
  logic             is_load, is_sw, is_sub;
  logic             misalign;
  logic             ld_go, sub_go;
  logic [15:0]      hw;
  logic [7:0]       by;
  logic [31:0]      ld_data;
  logic [31:0]      merged;

  // Upper address bits wrap away: the memory is only 4 KB.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:DM_AW+2];

  assign req_word = req_addr[DM_AW+1:2];
  assign is_load  = (req_op <= OP_LBU);
  assign is_sw    = (req_op == OP_SW);
  assign is_sub   = (req_op == OP_SH) || (req_op == OP_SB);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    unique case (req_op)
      OP_LW, OP_SW:         misalign = (req_addr[1:0] != 2'd0);
      OP_LH, OP_LHU, OP_SH: misalign = req_addr[0];
      default:              misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign ld_go  = (state == IDLE) && req_valid && is_load && !misalign;
  assign sub_go = (state == IDLE) && req_valid && is_sub && !misalign;

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    hw = req_addr[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    unique case (req_addr[1:0])
      2'd0:    by = dm_rdata[31:24];
      2'd1:    by = dm_rdata[23:16];
      2'd2:    by = dm_rdata[15:8];
      default: by = dm_rdata[7:0];
    endcase
  end

  always_comb begin
    ld_data = dm_rdata;
    unique case (req_op)
      OP_LH:   ld_data = {{16{hw[15]}}, hw};
      OP_LHU:  ld_data = {16'h0, hw};
      OP_LB:   ld_data = {{24{by[7]}}, by};
      OP_LBU:  ld_data = {24'h0, by};
      default: ld_data = dm_rdata;
    endcase
  end

  always_comb begin
    merged = dm_rdata;
    if (req_op == OP_SH) begin
      if (req_addr[1]) merged[15:0]  = req_wdata[15:0];
      else             merged[31:16] = req_wdata[15:0];
    end else begin
      unique case (req_addr[1:0])
        2'd0:    merged[31:24] = req_wdata[7:0];
        2'd1:    merged[23:16] = req_wdata[7:0];
        2'd2:    merged[15:8]  = req_wdata[7:0];
        default: merged[7:0]   = req_wdata[7:0];
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    dm_addr   = req_word;
    dm_wdata  = req_wdata;
    dm_we     = 1'b0;
    dm_re     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && !misalign) begin
          if (is_load) begin
            dm_re = 1'b1;
          end else if (is_sw) begin
            dm_we = 1'b1;
          end else begin
            dm_re     = 1'b1;
            stall     = 1'b1;
            state_nxt = RMW_WRITE;
          end
        end
      end
      default: begin
        dm_we     = 1'b1;
        dm_addr   = addr_reg;
        dm_wdata  = merge_reg;
        state_nxt = IDLE;
      end
    endcase
    // A reset cycle drops any pending write.
    if (reset) begin
      dm_we = 1'b0;
      dm_re = 1'b0;
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      merge_reg <= '0;
      addr_reg  <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      state    <= state_nxt;
      wb_valid <= ld_go;
      if (ld_go) begin
        wb_rd   <= req_rd;
        wb_data <= ld_data;
      end
      if (sub_go) begin
        merge_reg <= merged;
        addr_reg  <= req_word;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_misalign <= 1'b0;
      exc_addr     <= '0;
    end else begin
      exc_misalign <= (state == IDLE) && req_valid && misalign;
      if ((state == IDLE) && req_valid && misalign)
        exc_addr <= req_addr;
    end
  end
`else
  assign exc_misalign = 1'b0;
  assign exc_addr     = '0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu with a behavioural word memory.
// Ports: drives req_*, reset; models dm_*; checks stall/dm_*/wb_*/exc_*.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        stall;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic        dm_re;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misalign;
  logic [31:0] exc_addr;

  mem_lsu #(.DM_AW(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .stall(stall),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_we(dm_we), .dm_re(dm_re),
    .dm_rdata(dm_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_misalign(exc_misalign), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  assign dm_rdata = mem[dm_addr];
  always @(posedge clk)
    if (dm_we) mem[dm_addr] <= dm_wdata;

  logic [31:0] ref_mem [1024];

  typedef struct {
    int          cyc;
    bit          exc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] ext(logic [31:0] w,
                                      logic [2:0] o,
                                      logic [31:0] a);
    logic [7:0] b [4];
    int i, h;
    b[0] = w[31:24]; b[1] = w[23:16];
    b[2] = w[15:8];  b[3] = w[7:0];
    i = int'(a[1:0]);
    h = a[1] ? 2 : 0;
    case (o)
      3'd1: return {{16{b[h][7]}}, b[h], b[h+1]};
      3'd2: return {16'h0, b[h], b[h+1]};
      3'd3: return {{24{b[i][7]}}, b[i]};
      3'd4: return {24'h0, b[i]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] mrg(logic [31:0] w,
                                      logic [2:0] o,
                                      logic [31:0] a,
                                      logic [31:0] d);
    logic [7:0] b [4];
    int i, h;
    b[0] = w[31:24]; b[1] = w[23:16];
    b[2] = w[15:8];  b[3] = w[7:0];
    i = int'(a[1:0]);
    h = a[1] ? 2 : 0;
    if (o == 3'd6) begin
      b[h] = d[15:8];
      b[h+1] = d[7:0];
    end else begin
      b[i] = d[7:0];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic bit is_mis(logic [2:0] o, logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((o == 3'd0 || o == 3'd5) && a[1:0] != 2'd0) return 1'b1;
    if ((o == 3'd1 || o == 3'd2 || o == 3'd6) && a[0]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Output monitor: each due scoreboard entry must appear exactly
  // on its cycle; otherwise no result or trap may appear.
  always @(negedge clk) begin
    if (!reset && req_op !== 3'bx) begin
      if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.cyc < cyc) chk("late_result", 32'(cyc), 32'(e.cyc));
        if (e.exc) begin
          chk("exc_pulse", 32'(exc_misalign), 32'd1);
          chk("exc_addr", exc_addr, e.data);
          chk("exc_wbv", 32'(wb_valid), 32'd0);
        end else begin
          chk("wb_valid", 32'(wb_valid), 32'd1);
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.data);
        end
      end else begin
        chk("idle_wbv", 32'(wb_valid), 32'd0);
        chk("idle_exc", 32'(exc_misalign), 32'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    logic [9:0]  wa;
    logic [31:0] m;
    exp_t e;
    wa = a[11:2];
    req_valid = 1'b1;
    req_op    = o;
    req_addr  = a;
    req_wdata = wd;
    req_rd    = rd;
    @(negedge clk);
    if (is_mis(o, a)) begin
      chk("mis_re", 32'(dm_re), 32'd0);
      chk("mis_we", 32'(dm_we), 32'd0);
      chk("mis_stall", 32'(stall), 32'd0);
      e.cyc = cyc + 1; e.exc = 1'b1; e.rd = 5'd0; e.data = a;
      sb_q.push_back(e);
    end else if (o <= 3'd4) begin
      chk("ld_re", 32'(dm_re), 32'd1);
      chk("ld_we", 32'(dm_we), 32'd0);
      chk("ld_addr", 32'(dm_addr), 32'(wa));
      chk("ld_stall", 32'(stall), 32'd0);
      e.cyc = cyc + 1; e.exc = 1'b0; e.rd = rd;
      e.data = ext(ref_mem[wa], o, a);
      sb_q.push_back(e);
    end else if (o == 3'd5) begin
      chk("sw_we", 32'(dm_we), 32'd1);
      chk("sw_addr", 32'(dm_addr), 32'(wa));
      chk("sw_data", dm_wdata, wd);
      chk("sw_stall", 32'(stall), 32'd0);
      ref_mem[wa] = wd;
    end else begin
      m = mrg(ref_mem[wa], o, a, wd);
      chk("rmw1_stall", 32'(stall), 32'd1);
      chk("rmw1_re", 32'(dm_re), 32'd1);
      chk("rmw1_we", 32'(dm_we), 32'd0);
      @(posedge clk);
      #1;
      req_addr = 32'hFFFF_FFFC;
      req_wdata = 32'h0;
      @(negedge clk);
      chk("rmw2_stall", 32'(stall), 32'd0);
      chk("rmw2_we", 32'(dm_we), 32'd1);
      chk("rmw2_re", 32'(dm_re), 32'd0);
      chk("rmw2_addr", 32'(dm_addr), 32'(wa));
      chk("rmw2_data", dm_wdata, m);
      ref_mem[wa] = m;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_re", 32'(dm_re), 32'd0);
      chk("idle_we", 32'(dm_we), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 3'bx;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    req_rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op = 3'd5;
    @(negedge clk);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wbrd", 32'(wb_rd), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_exc", 32'(exc_misalign), 32'd0);
    chk("rst_excaddr", exc_addr, 32'd0);
    chk("rst_we", 32'(dm_we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b0;
    idle(1);

    issue(3'd5, 32'h10, 32'h12345678, 5'd0);
    issue(3'd0, 32'h10, 32'h0, 5'd5);
    issue(3'd7, 32'h11, 32'h000000AB, 5'd0);
    issue(3'd3, 32'h11, 32'h0, 5'd6);
    issue(3'd4, 32'h11, 32'h0, 5'd7);
    idle(1);
    chk("hold_data", wb_data, 32'h000000AB);
    chk("hold_rd", 32'(wb_rd), 32'd7);
    issue(3'd6, 32'h12, 32'h00008001, 5'd0);
    issue(3'd1, 32'h12, 32'h0, 5'd8);
    issue(3'd2, 32'h12, 32'h0, 5'd9);

    issue(3'd5, 32'h20, 32'h0, 5'd0);
    issue(3'd7, 32'h23, 32'h0000005A, 5'd0);
    issue(3'd6, 32'h20, 32'h0000C3C3, 5'd0);
    issue(3'd7, 32'h21, 32'h00000077, 5'd0);
    issue(3'd0, 32'h20, 32'h0, 5'd10);

    issue(3'd0, 32'h13, 32'h0, 5'd11);
    issue(3'd1, 32'h13, 32'h0, 5'd12);
    issue(3'd3, 32'h10, 32'h0, 5'd0);
    idle(2);

    req_valid = 1'b1;
    req_op = 3'd7;
    req_addr = 32'h10;
    req_wdata = 32'hFF;
    @(negedge clk);
    chk("rr_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rr_we", 32'(dm_we), 32'd0);
    chk("rr_re", 32'(dm_re), 32'd0);
    chk("rr_stall0", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rr_wbdata", wb_data, 32'd0);
    chk("rr_wbrd", 32'(wb_rd), 32'd0);
    chk("rr_excaddr", exc_addr, 32'd0);
    @(posedge clk);
    #1;
    issue(3'd0, 32'h10, 32'h0, 5'd13);

    issue(3'd5, 32'h1010, 32'hDEADBEEF, 5'd0);
    issue(3'd0, 32'h10, 32'h0, 5'd14);
    issue(3'd0, 32'h8000_0010, 32'h0, 5'd15);
    idle(3);

    for (int k = 0; k < 5 && sb_q.size() > 0; k++) idle(1);
    if (sb_q.size() != 0) chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit sitting directly upstream of the word-wide data memory.
- Decodes MIPS sub-word loads and stores and drives the memory's word address, write data and enables.
- Sub-word stores are done as a read-modify-write, because the memory writes only whole words.
- Sign/zero-extends load data into a registered result for the MEM/WB boundary.

Parameters:
DM_AW, 10, word-address width driven to the data memory (word address = byte address [DM_AW+1:2])

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  memory request present this cycle
req_op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
req_addr  input  32  byte address
req_wdata  input  32  store data; low byte/halfword used for SB/SH
req_rd  input  5  load destination register
stall  output  1  upstream must hold its request this cycle
dm_addr  output  DM_AW  word address to data memory
dm_wdata  output  32  write data to data memory
dm_we  output  1  data memory write enable (write at posedge)
dm_re  output  1  data memory read enable
dm_rdata  input  32  data memory read word, combinational from dm_addr
wb_valid  output  1  one-cycle pulse: load result valid
wb_rd  output  5  load destination register
wb_data  output  32  extended load result
exc_misalign  output  1  one-cycle pulse: misaligned access
exc_addr  output  32  faulting byte address

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - state IDLE.
  - wb_valid, wb_rd, wb_data = 0.
  - exc_misalign, exc_addr = 0.
  - Internal merge_reg and addr_reg = 0.
- dm_we and dm_re are forced 0 in any cycle where reset=1, including reset asserted during RMW_WRITE. The pending write is dropped and memory is unchanged.
- Byte order is big-endian. Byte lane for addr[1:0]=0 is bits 31:24; halfword for addr[1]=0 is bits 31:16.
- Upper address bits above DM_AW+1 are ignored, so addresses wrap modulo 4 KB.
- dm_addr, dm_wdata, dm_we, dm_re are combinational from state and the request.
- State IDLE, req_valid=1:
  - Loads: dm_re=1, dm_addr=req_addr word. At posedge, wb_data is set to the extracted lane, sign-extended for LH/LB and zero-extended for LHU/LBU. wb_rd is set to req_rd and wb_valid pulses 1 next cycle. Latency 1, stall=0.
  - SW: dm_we=1, dm_wdata=req_wdata, stall=0. Memory is updated at that posedge.
  - SH/SB, cycle 1:
    - dm_re=1 and stall=1.
    - At posedge, merge_reg is set to dm_rdata with the target lane replaced by req_wdata[15:0] or [7:0]. addr_reg is set to the word address.
    - State goes to RMW_WRITE.
- State RMW_WRITE:
  - dm_we=1, dm_addr=addr_reg, dm_wdata=merge_reg, dm_re=0, stall=0.
  - req_* inputs are ignored; upstream advances at this edge.
  - Next state IDLE.
  - Every SH/SB therefore costs exactly 2 cycles with exactly 1 stall cycle.
- req_valid=0 in IDLE: no memory enables asserted, wb_valid=0 next cycle.
- A load issued the cycle after a store sees the new data, because the write is committed at the preceding edge.
- wb_valid has no back-pressure. req_rd=0 still produces a wb_valid pulse with wb_rd=0.
- wb_data and wb_rd hold their last value when wb_valid=0.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1.
  - A misaligned request asserts no dm_re/dm_we and has stall=0.
  - exc_misalign pulses 1 next cycle with exc_addr=req_addr, and wb_valid=0.
- Undefined:
  - Alignment bits below the access size are ignored: treated as 0 for word and halfword selection.
  - exc_misalign and exc_addr are tied to 0.

Test Plan:
- Reset, then SW 0x12345678 @0x10, then LW @0x10 with rd=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x12345678.
- SB 0xAB @0x11 -> stall=1 for exactly one cycle; RMW cycle dm_we=1 with dm_wdata=0x12AB5678. Then LB @0x11 -> 0xFFFFFFAB, and LBU @0x11 -> 0x000000AB.
- SH 0x8001 @0x12 -> word becomes 0x12AB8001. LH @0x12 -> 0xFFFF8001; LHU @0x12 -> 0x00008001. Back-to-back SB then SH yield correct merged words with no lost update.
- LW @0x13 with LSU_MISALIGN_TRAP_EN -> exc_misalign=1, exc_addr=0x13, no dm_re/dm_we, wb_valid=0. Without the macro -> wb_data=0x12AB8001.
- Reset asserted during the RMW_WRITE cycle of SB 0xFF @0x10 -> dm_we=0, word stays 0x12AB8001, state IDLE, all outputs 0.
- SW 0xDEADBEEF @0x1010, then LW @0x10 -> wb_data=0xDEADBEEF (address wrap).
